// File: rtl/capcnt_bank.sv
// capcnt_bank: bank of N independent event counters with a global snapshot.
// Each channel counts cycles with its inc strobe high (wrapping or saturating
// per SAT), flags overflow stickily, and copies its count into a capture
// register on cap. One channel is read out through registered ports.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_inc        per-channel increment strobes
//   i_cap        global capture strobe
//   i_clr_on_cap 1: counters restart on capture; sampled only when i_cap=1
//   i_ovf_clr    per-channel sticky-overflow clear strobes
//   i_rd_sel     readout channel select (>= N reads zero)
//   o_rd_cur     selected channel's current count, one cycle latency
//   o_rd_cap     selected channel's captured count, one cycle latency
//   o_ovf        sticky overflow flags
//   o_cap_done   pulse in the cycle after each capture
module capcnt_bank #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 16,
    parameter int unsigned SAT = 0,
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_inc,
    input  logic          i_cap,
    input  logic          i_clr_on_cap,
    input  logic [N-1:0]  i_ovf_clr,
    input  logic [SW-1:0] i_rd_sel,
    output logic [W-1:0]  o_rd_cur,
    output logic [W-1:0]  o_rd_cap,
    output logic [N-1:0]  o_ovf,
    output logic          o_cap_done
);

    logic [W-1:0] r_cur  [N];
    logic [W-1:0] r_capr [N];
    logic [N-1:0] r_ovf;
    logic [W-1:0] r_rd_cur;
    logic [W-1:0] r_rd_cap;
    logic         r_cap_done;

    logic [W-1:0] w_cur_nxt [N];
    logic [N-1:0] w_ovf_nxt;
    logic         w_restart;
    logic [W-1:0] w_rd_cur;
    logic [W-1:0] w_rd_cap;

    // Next counter value and sticky overflow; overflow set beats clear.
    always_comb begin
        w_restart = i_cap & i_clr_on_cap;
        for (int i = 0; i < N; i++) begin
            w_cur_nxt[i] = r_cur[i];
            w_ovf_nxt[i] = (i_inc[i] & (&r_cur[i])) | (r_ovf[i] & ~i_ovf_clr[i]);
            if (w_restart) begin
                // Restart counts this cycle's increment, if any.
                w_cur_nxt[i] = W'(i_inc[i]);
            end else if (i_inc[i] && !((SAT != 0) && (&r_cur[i]))) begin
                w_cur_nxt[i] = r_cur[i] + W'(1);
            end
        end
    end

    // Readout mux; unmatched selects (>= N) fall through to zero.
    always_comb begin
        w_rd_cur = '0;
        w_rd_cap = '0;
        for (int i = 0; i < N; i++) begin
            if (i_rd_sel == SW'(i)) begin
                w_rd_cur = r_cur[i];
                w_rd_cap = r_capr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_cur[i]  <= '0;
                r_capr[i] <= '0;
            end
            r_ovf      <= '0;
            r_rd_cur   <= '0;
            r_rd_cap   <= '0;
            r_cap_done <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                r_cur[i] <= w_cur_nxt[i];
                // Snapshot the pre-edge count; this cycle's inc is excluded.
                if (i_cap) begin
                    r_capr[i] <= r_cur[i];
                end
            end
            r_ovf      <= w_ovf_nxt;
            r_rd_cur   <= w_rd_cur;
            r_rd_cap   <= w_rd_cap;
            r_cap_done <= i_cap;
        end
    end

    assign o_rd_cur   = r_rd_cur;
    assign o_rd_cap   = r_rd_cap;
    assign o_ovf      = r_ovf;
    assign o_cap_done = r_cap_done;

endmodule

// File: tb/tb_capcnt_bank.sv
// Bench for capcnt_bank: five configurations share one stimulus bus and are
// compared every cycle against an arithmetic reference model, plus directed
// scenario checks with hand-derived constants.
module tb_capcnt_bank;

    localparam int unsigned NI = 5;
    localparam int unsigned P_N  [NI] = '{4, 1, 1, 3, 8};
    localparam int unsigned P_W  [NI] = '{16, 8, 8, 8, 8};
    localparam int unsigned P_S  [NI] = '{0, 0, 1, 1, 0};
    localparam int unsigned P_SW [NI] = '{2, 1, 1, 2, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] inc = '0;
    logic       cap = 1'b0;
    logic       clr_on_cap = 1'b0;
    logic [7:0] ovf_clr = '0;
    logic [2:0] rd_sel = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logic [15:0] rc0, rk0;
    logic [3:0]  ov0;
    logic [7:0]  rc1, rk1, rc2, rk2, rc3, rk3, rc4, rk4;
    logic [0:0]  ov1, ov2;
    logic [2:0]  ov3;
    logic [7:0]  ov4;
    logic        cd0, cd1, cd2, cd3, cd4;

    capcnt_bank #(.N(4), .W(16), .SAT(0)) u0 (
        .clk(clk), .rst(rst), .i_inc(inc[3:0]), .i_cap(cap), .i_clr_on_cap(clr_on_cap),
        .i_ovf_clr(ovf_clr[3:0]), .i_rd_sel(rd_sel[1:0]),
        .o_rd_cur(rc0), .o_rd_cap(rk0), .o_ovf(ov0), .o_cap_done(cd0));
    capcnt_bank #(.N(1), .W(8), .SAT(0)) u1 (
        .clk(clk), .rst(rst), .i_inc(inc[0:0]), .i_cap(cap), .i_clr_on_cap(clr_on_cap),
        .i_ovf_clr(ovf_clr[0:0]), .i_rd_sel(rd_sel[0:0]),
        .o_rd_cur(rc1), .o_rd_cap(rk1), .o_ovf(ov1), .o_cap_done(cd1));
    capcnt_bank #(.N(1), .W(8), .SAT(1)) u2 (
        .clk(clk), .rst(rst), .i_inc(inc[0:0]), .i_cap(cap), .i_clr_on_cap(clr_on_cap),
        .i_ovf_clr(ovf_clr[0:0]), .i_rd_sel(rd_sel[0:0]),
        .o_rd_cur(rc2), .o_rd_cap(rk2), .o_ovf(ov2), .o_cap_done(cd2));
    capcnt_bank #(.N(3), .W(8), .SAT(1)) u3 (
        .clk(clk), .rst(rst), .i_inc(inc[2:0]), .i_cap(cap), .i_clr_on_cap(clr_on_cap),
        .i_ovf_clr(ovf_clr[2:0]), .i_rd_sel(rd_sel[1:0]),
        .o_rd_cur(rc3), .o_rd_cap(rk3), .o_ovf(ov3), .o_cap_done(cd3));
    capcnt_bank #(.N(8), .W(8), .SAT(0)) u4 (
        .clk(clk), .rst(rst), .i_inc(inc), .i_cap(cap), .i_clr_on_cap(clr_on_cap),
        .i_ovf_clr(ovf_clr), .i_rd_sel(rd_sel),
        .o_rd_cur(rc4), .o_rd_cap(rk4), .o_ovf(ov4), .o_cap_done(cd4));

    // Uniform views of every instance's outputs.
    logic [31:0] d_rc [NI];
    logic [31:0] d_rk [NI];
    logic [7:0]  d_ov [NI];
    logic        d_cd [NI];
    assign d_rc[0] = 32'(rc0);  assign d_rk[0] = 32'(rk0);  assign d_ov[0] = 8'(ov0);  assign d_cd[0] = cd0;
    assign d_rc[1] = 32'(rc1);  assign d_rk[1] = 32'(rk1);  assign d_ov[1] = 8'(ov1);  assign d_cd[1] = cd1;
    assign d_rc[2] = 32'(rc2);  assign d_rk[2] = 32'(rk2);  assign d_ov[2] = 8'(ov2);  assign d_cd[2] = cd2;
    assign d_rc[3] = 32'(rc3);  assign d_rk[3] = 32'(rk3);  assign d_ov[3] = 8'(ov3);  assign d_cd[3] = cd3;
    assign d_rc[4] = 32'(rc4);  assign d_rk[4] = 32'(rk4);  assign d_ov[4] = 8'(ov4);  assign d_cd[4] = cd4;

    // Reference model state.
    longint m_cur  [NI][8];
    longint m_capr [NI][8];
    bit     m_ovf  [NI][8];
    longint m_rc   [NI];
    longint m_rk   [NI];
    bit     m_cd   [NI];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of behaviour to the model using the inputs
    // currently on the bus.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            longint mx  = (longint'(1) << P_W[k]) - 1;
            int     n   = int'(P_N[k]);
            int     sel = int'(rd_sel) % (1 << P_SW[k]);
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    m_cur[k][i] = 0; m_capr[k][i] = 0; m_ovf[k][i] = 0;
                end
                m_rc[k] = 0; m_rk[k] = 0; m_cd[k] = 0;
            end else begin
                m_rc[k] = (sel < n) ? m_cur[k][sel]  : 0;
                m_rk[k] = (sel < n) ? m_capr[k][sel] : 0;
                m_cd[k] = cap;
                for (int i = 0; i < n; i++) begin
                    bit b = inc[i];
                    m_ovf[k][i] = (b && m_cur[k][i] == mx) || (m_ovf[k][i] && !ovf_clr[i]);
                    if (cap) m_capr[k][i] = m_cur[k][i];
                    if (cap && clr_on_cap) begin
                        m_cur[k][i] = b ? 1 : 0;
                    end else if (b) begin
                        if (P_S[k] != 0) m_cur[k][i] = (m_cur[k][i] + 1 > mx) ? mx : m_cur[k][i] + 1;
                        else             m_cur[k][i] = (m_cur[k][i] + 1) % (mx + 1);
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NI; k++) begin
            logic [7:0] e_ov = '0;
            for (int i = 0; i < int'(P_N[k]); i++) e_ov[i] = m_ovf[k][i];
            chk($sformatf("u%0d_rd_cur", k),   64'(d_rc[k]), 64'(m_rc[k]));
            chk($sformatf("u%0d_rd_cap", k),   64'(d_rk[k]), 64'(m_rk[k]));
            chk($sformatf("u%0d_ovf", k),      64'(d_ov[k]), 64'(e_ov));
            chk($sformatf("u%0d_cap_done", k), 64'(d_cd[k]), 64'(m_cd[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        inc = '0; cap = 1'b0; clr_on_cap = 1'b0; ovf_clr = '0; rd_sel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_rd_cur", 64'(rc0), 64'd0);
        chk("rst_ovf", 64'(ov4), 64'd0);
        rst = 1'b0;

        // Five incs on channel 2, capture without restart
        do_reset();
        inc = 8'b0000_0100;
        repeat (5) step();
        inc = '0; cap = 1'b1; clr_on_cap = 1'b0; rd_sel = 3'd2;
        step();
        chk("c1_cap_done_hi", 64'(cd0), 64'd1);
        cap = 1'b0;
        step();
        chk("c1_rd_cap", 64'(rk0), 64'd5);
        chk("c1_rd_cur", 64'(rc0), 64'd5);
        chk("c1_cap_done_lo", 64'(cd0), 64'd0);
        for (int s = 0; s < 4; s++) begin
            if (s == 2) continue;
            rd_sel = 3'(s);
            step();
            chk($sformatf("c1_other%0d_cur", s), 64'(rc0), 64'd0);
            chk($sformatf("c1_other%0d_cap", s), 64'(rk0), 64'd0);
        end

        // Capture with restart while incrementing
        do_reset();
        inc = 8'b1;
        repeat (7) step();
        cap = 1'b1; clr_on_cap = 1'b1;
        step();
        idle_inputs();
        step();
        chk("c2_rd_cap", 64'(rk0), 64'd7);
        chk("c2_rd_cur", 64'(rc0), 64'd1);

        // Wrap at 255 and sticky overflow clear
        do_reset();
        inc = 8'b1;
        repeat (255) step();
        inc = '0;
        step();
        chk("c3_cur255", 64'(rc1), 64'd255);
        chk("c3_no_ovf", 64'(ov1), 64'd0);
        inc = 8'b1;
        step();
        chk("c3_ovf_set", 64'(ov1), 64'd1);
        inc = '0;
        step();
        chk("c3_wrapped", 64'(rc1), 64'd0);
        chk("c3_sat_hold", 64'(rc2), 64'd255);
        ovf_clr = 8'b1;
        step();
        chk("c3_ovf_clr", 64'(ov1), 64'd0);
        ovf_clr = '0;

        // Saturation over 300 incs, set wins over clear
        do_reset();
        inc = 8'b1;
        repeat (300) step();
        inc = '0;
        step();
        chk("c4_sat_cur", 64'(rc2), 64'd255);
        chk("c4_sat_ovf", 64'(ov2), 64'd1);
        inc = 8'b1; ovf_clr = 8'b1;
        step();
        chk("c4_set_wins", 64'(ov2), 64'd1);
        inc = '0;
        step();
        chk("c4_cleared", 64'(ov2), 64'd0);
        ovf_clr = '0;

        // Reset mid-count with coincident capture
        do_reset();
        inc = 8'b10;
        repeat (40) step();
        inc = '0; rd_sel = 3'd1;
        step();
        chk("c5_cur40", 64'(rc0), 64'd40);
        rst = 1'b1; cap = 1'b1; inc = 8'b10;
        step();
        chk("c5_rd_cur0", 64'(rc0), 64'd0);
        chk("c5_rd_cap0", 64'(rk0), 64'd0);
        chk("c5_ovf0", 64'(ov0), 64'd0);
        chk("c5_no_done", 64'(cd0), 64'd0);
        rst = 1'b0; cap = 1'b0;
        repeat (3) step();
        inc = '0;
        step();
        chk("c5_cur3", 64'(rc0), 64'd3);
        chk("c5_done_lo", 64'(cd0), 64'd0);

        // Randomized traffic; restarts and resets only in the first half so
        // the 8-bit counters also reach overflow later on.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            inc        = 8'($urandom) | 8'($urandom);
            cap        = ($urandom % 16) == 0;
            clr_on_cap = (c < 5000) ? 1'($urandom) : 1'b0;
            ovf_clr    = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
            rd_sel     = 3'($urandom);
            rst        = (c < 5000) && (($urandom % 700) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
